seq_divmod: RTL and testbench

SEQ_DIVMOD -- requirements
Module: seq_divmod

---
 rtl/seq_divmod_pkg.sv | 19 +
 rtl/seq_divmod_step.sv | 31 +++
 rtl/seq_divmod.sv | 104 ++++++++++
 tb/tb_seq_divmod.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divmod_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divmod_pkg
//  Description : Shared FSM state type and default widths for seq_divmod.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_divmod_pkg;

  localparam int DIVMOD_DIVIDEND_W = 6;
  localparam int DIVMOD_DIVISOR_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divmod_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divmod_step.sv
`default_nettype none
// ============================================================================
//  Module      : divmod_step
//  Description : One restoring-division step: shift in a dividend bit,
//                subtract the divisor when it fits, emit the quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module divmod_step
  import seq_divmod_pkg::*;
#(
  parameter int DIVISOR_W = DIVMOD_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   prem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   prem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] w_shifted;
  logic [DIVISOR_W:0]   w_diff;

  assign w_shifted = {prem_in, bit_in};
  assign q_bit     = (w_shifted >= {2'b00, divisor});
  // When the divisor fits, the difference is below the divisor, so the
  // narrower subtraction cannot lose significant bits.
  assign w_diff    = w_shifted[DIVISOR_W:0] - {1'b0, divisor};
  assign prem_out  = q_bit ? w_diff : w_shifted[DIVISOR_W:0];

endmodule
`default_nettype wire

// File: rtl/seq_divmod.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divmod
//  Description : Sequential unsigned divider, one quotient bit per cycle,
//                with ready/valid handshakes on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divmod
  import seq_divmod_pkg::*;
#(
  parameter int DIVIDEND_W = DIVMOD_DIVIDEND_W,
  parameter int DIVISOR_W  = DIVMOD_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int                 c_CNT_W     = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(DIVIDEND_W - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  divmod_state_t         r_state;
  divmod_state_t         w_next_state;
  logic [DIVIDEND_W-1:0] r_work;
  logic [DIVISOR_W-1:0]  r_divisor;
  logic [DIVISOR_W:0]    r_prem;
  logic [c_CNT_W-1:0]    r_count;
  logic                  r_dbz;

  logic                  w_accept;
  logic                  w_div_zero;
  logic [DIVISOR_W:0]    w_prem_next;
  logic                  w_q_bit;

  assign w_accept   = start && (r_state == IDLE);
  assign w_div_zero = (divisor == '0);

  divmod_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .prem_in  (r_prem),
    .bit_in   (r_work[DIVIDEND_W-1]),
    .divisor  (r_divisor),
    .prem_out (w_prem_next),
    .q_bit    (w_q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = w_div_zero ? DONE : BUSY;
      BUSY:    if (r_count == c_LAST_STEP) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // r_work holds the unconsumed dividend bits; quotient bits shift in from
  // the right, so after the last step it contains the full quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work    <= '0;
      r_divisor <= '0;
      r_prem    <= '0;
      r_count   <= '0;
      r_dbz     <= 1'b0;
    end else if (w_accept) begin
      r_work    <= w_div_zero ? '1 : dividend;
      r_divisor <= divisor;
      r_prem    <= '0;
      r_count   <= '0;
      r_dbz     <= w_div_zero;
    end else if (r_state == BUSY) begin
      r_work    <= {r_work[DIVIDEND_W-2:0], w_q_bit};
      r_prem    <= w_prem_next;
      r_count   <= r_count + c_CNT_ONE;
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_work;
  assign remainder   = r_prem[DIVISOR_W-1:0];
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divmod.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_seq_divmod
//  Description : Self-checking bench for seq_divmod (6/4 and 8/8 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divmod;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_ready;
  logic [5:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  logic       b_start;
  logic       b_in_ready;
  logic [7:0] b_dividend;
  logic [7:0] b_divisor;
  logic       b_out_valid;
  logic       b_out_ready;
  logic [7:0] b_quotient;
  logic [7:0] b_remainder;
  logic       b_div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_divmod dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  seq_divmod #(
    .DIVIDEND_W (8),
    .DIVISOR_W  (8)
  ) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (b_start),
    .in_ready    (b_in_ready),
    .dividend    (b_dividend),
    .divisor     (b_divisor),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready),
    .quotient    (b_quotient),
    .remainder   (b_remainder),
    .div_by_zero (b_div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge with the 6/4 instance idle.
  task automatic run_op(input int dd, input int dv, input int hold);
    int exp_q, exp_r, exp_z, exp_lat, cyc;
    exp_q   = (dv == 0) ? 63 : dd / dv;
    exp_r   = (dv == 0) ? 0  : dd % dv;
    exp_z   = (dv == 0) ? 1  : 0;
    // A zero divisor goes straight to DONE on the accepting edge.
    exp_lat = (dv == 0) ? 0  : 6;
    check("in_ready_idle", 32'(in_ready), 1);
    start     = 1'b1;
    dividend  = 6'(dd);
    divisor   = 4'(dv);
    out_ready = 1'b0;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    while (!out_valid && cyc < 64) begin
      start    = 1'($urandom_range(0, 1));
      dividend = 6'($urandom);
      divisor  = 4'($urandom);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("out_valid", 32'(out_valid), 1);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("quotient", 32'(quotient), 32'(exp_q));
    check("remainder", 32'(remainder), 32'(exp_r));
    check("div_by_zero", 32'(div_by_zero), 32'(exp_z));
    check("in_ready_done", 32'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      start    = 1'($urandom_range(0, 1));
      dividend = 6'($urandom);
      divisor  = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_quotient", 32'(quotient), 32'(exp_q));
      check("hold_remainder", 32'(remainder), 32'(exp_r));
      check("hold_dbz", 32'(div_by_zero), 32'(exp_z));
      check("hold_in_ready", 32'(in_ready), 0);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 0);
    check("release_in_ready", 32'(in_ready), 1);
  endtask

  // 8/8 instance, consumer always ready.
  task automatic run_b(input int dd, input int dv);
    int exp_q, exp_r, exp_z, exp_lat, cyc;
    exp_q   = (dv == 0) ? 255 : dd / dv;
    exp_r   = (dv == 0) ? 0   : dd % dv;
    exp_z   = (dv == 0) ? 1   : 0;
    exp_lat = (dv == 0) ? 0   : 8;
    b_start    = 1'b1;
    b_dividend = 8'(dd);
    b_divisor  = 8'(dv);
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    b_start    = 1'b0;
    b_dividend = 8'($urandom);
    b_divisor  = 8'($urandom);
    while (!b_out_valid && cyc < 64) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("b_latency", 32'(cyc), 32'(exp_lat));
    check("b_quotient", 32'(b_quotient), 32'(exp_q));
    check("b_remainder", 32'(b_remainder), 32'(exp_r));
    check("b_div_by_zero", 32'(b_div_by_zero), 32'(exp_z));
    @(posedge clk);
    @(negedge clk);
    check("b_in_ready", 32'(b_in_ready), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    dividend    = '0;
    divisor     = '0;
    out_ready   = 1'b0;
    b_start     = 1'b0;
    b_dividend  = '0;
    b_divisor   = '0;
    b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_quotient", 32'(quotient), 0);
    check("rst_remainder", 32'(remainder), 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(59, 10, 0);
    run_op(63, 6, 0);
    run_op(0, 7, 0);
    run_op(42, 0, 0);
    run_op(59, 10, 5);
    run_op(42, 0, 5);

    // Abort an operation in its third BUSY cycle.
    start    = 1'b1;
    dividend = 6'd20;
    divisor  = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_quotient", 32'(quotient), 0);
    check("abort_remainder", 32'(remainder), 0);
    check("abort_dbz", 32'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_result", 32'(out_valid), 0);
    run_op(45, 10, 2);

    for (int dd = 0; dd < 64; dd++) begin
      for (int dv = 0; dv < 16; dv++) begin
        run_op(dd, dv, int'($urandom_range(0, 2)));
      end
    end

    run_b(255, 1);
    run_b(255, 255);
    run_b(0, 0);
    run_b(200, 7);
    for (int i = 0; i < 300; i++) begin
      run_b(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
